// File: rtl/band_pkg.sv
// band_pkg: shared definitions for the band binner.
//   mode_e          per-frame reduction mode (sum / mean / peak)
//   decode_mode     maps the raw 2-bit mode field onto mode_e (3 folds to sum)
//   floor_log2      integer floor(log2(v)), v >= 1
//   band_edge       first bin of band b (b == BANDS gives FFT_LEN/2)
//   max_band_width  widest band for a given edge configuration
//   acc_width       accumulator width that holds a full-band sum without overflow
package band_pkg;

    typedef enum logic [1:0] {
        MODE_SUM  = 2'd0,
        MODE_MEAN = 2'd1,
        MODE_PEAK = 2'd2
    } mode_e;

    // ln(2) in Q30, used by the integer 2^x evaluation below
    localparam longint LN2_Q30 = 64'd744261118;
    localparam longint ONE_Q30 = 64'd1 << 30;

    function automatic mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return MODE_MEAN;
            2'd2:    return MODE_PEAK;
            default: return MODE_SUM;
        endcase
    endfunction

    function automatic int floor_log2(input int v);
        int r;
        int x;
        r = 0;
        x = v;
        while (x > 1) begin
            x = x >> 1;
            r++;
        end
        return r;
    endfunction

    // round(2^(ipart + rem/den)) using a Q30 Taylor series for e^(frac*ln2),
    // so the geometric edges need no real arithmetic at elaboration.
    function automatic int pow2_round(input int ipart, input int rem, input int den);
        longint x;
        longint term;
        longint acc;
        x    = (longint'(rem) * LN2_Q30) / longint'(den);
        term = ONE_Q30;
        acc  = ONE_Q30;
        for (int n = 1; n < 16; n++) begin
            term = ((term * x) >>> 30) / longint'(n);
            acc  = acc + term;
        end
        return int'(((acc << ipart) + (ONE_Q30 >>> 1)) >>> 30);
    endfunction

    function automatic int band_edge(input int b, input int fft_len, input int bands,
                                     input int edge_log, input int skip_dc);
        int half;
        int l2;
        int e;
        int g;
        half = fft_len / 2;
        l2   = floor_log2(half);
        if (b <= 0)
            return skip_dc;
        if (b >= bands)
            return half;
        if (edge_log == 0)
            return (b * half) / bands;
        // geometric points half^(k/bands), pushed up to keep every band at least
        // one bin wide and capped so the remaining bands still fit below half
        e = skip_dc;
        for (int k = 1; k <= b; k++) begin
            g = pow2_round((l2 * k) / bands, (l2 * k) % bands, bands);
            if (g < e + 1)
                g = e + 1;
            if (g > half - (bands - k))
                g = half - (bands - k);
            e = g;
        end
        return e;
    endfunction

    function automatic int max_band_width(input int fft_len, input int bands,
                                          input int edge_log, input int skip_dc);
        int m;
        int w;
        m = 0;
        for (int b = 0; b < bands; b++) begin
            w = band_edge(b + 1, fft_len, bands, edge_log, skip_dc)
              - band_edge(b, fft_len, bands, edge_log, skip_dc);
            if (w > m)
                m = w;
        end
        return m;
    endfunction

    // extra bits = bits needed to hold the bin count of the widest band
    function automatic int acc_width(input int in_width, input int fft_len, input int bands,
                                     input int edge_log, input int skip_dc);
        return in_width + $clog2(max_band_width(fft_len, bands, edge_log, skip_dc) + 1);
    endfunction

endpackage

// File: rtl/band_edge_table.sv
// band_edge_table: constant ROM built at elaboration from band_edge().
//   band      in   band index
//   last_bin  out  last bin belonging to that band (E[b+1]-1)
//   shift     out  floor(log2(band width)), the mean-mode divide shift
module band_edge_table
    import band_pkg::*;
#(
    parameter int FFT_LEN  = 1024,
    parameter int BANDS    = 32,
    parameter int EDGE_LOG = 0,
    parameter int SKIP_DC  = 1,
    parameter int BIN_W    = $clog2(FFT_LEN),
    parameter int BAND_W   = $clog2(BANDS),
    parameter int SH_W     = $clog2(BIN_W)
)
(
    input  logic [BAND_W-1:0] band,
    output logic [BIN_W-1:0]  last_bin,
    output logic [SH_W-1:0]   shift
);

    logic [BIN_W-1:0] last_rom  [BANDS];
    logic [SH_W-1:0]  shift_rom [BANDS];

    for (genvar g = 0; g < BANDS; g++) begin : g_rom
        localparam int LO = band_edge(g, FFT_LEN, BANDS, EDGE_LOG, SKIP_DC);
        localparam int HI = band_edge(g + 1, FFT_LEN, BANDS, EDGE_LOG, SKIP_DC);
        assign last_rom[g]  = BIN_W'(HI - 1);
        assign shift_rom[g] = SH_W'(floor_log2(HI - LO));
    end

    assign last_bin = last_rom[band];
    assign shift    = shift_rom[band];

endmodule

// File: rtl/band_binner.sv
// band_binner: folds one FFT magnitude frame into BANDS display bands.
//   clk_50m, rst_n                 clock, synchronous active-low reset
//   cfg_mode                       0 sum, 1 mean, 2 peak, 3 sum; taken at bin 0
//   s_axis_tvalid/tready/tdata/tlast   magnitude stream, one bin per beat
//   m_axis_tvalid/tready/tdata/tuser/tlast  one beat per band, tuser = band
//   frame_err                      one-cycle pulse on tlast misalignment
module band_binner
    import band_pkg::*;
#(
    parameter int FFT_LEN   = 1024,
    parameter int BANDS     = 32,
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = 16,
    parameter int EDGE_LOG  = 0,
    parameter int SKIP_DC   = 1
)
(
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic [1:0]               cfg_mode,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [IN_WIDTH-1:0]      s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [OUT_WIDTH-1:0]     m_axis_tdata,
    output logic [$clog2(BANDS)-1:0] m_axis_tuser,
    output logic                     m_axis_tlast,
    output logic                     frame_err
);

    localparam int BIN_W  = $clog2(FFT_LEN);
    localparam int BAND_W = $clog2(BANDS);
    localparam int SH_W   = $clog2(BIN_W);
    localparam int ACC_W  = acc_width(IN_WIDTH, FFT_LEN, BANDS, EDGE_LOG, SKIP_DC);

    logic [BIN_W-1:0]     bin;
    logic [BAND_W-1:0]    band;
    mode_e                mode_q;
    mode_e                mode_eff;
    logic [ACC_W-1:0]     acc;
    logic                 acc_empty;
    logic [ACC_W-1:0]     din_ext;
    logic [ACC_W-1:0]     new_val;
    logic [ACC_W-1:0]     mean_full;
    logic [OUT_WIDTH-1:0] result;
    logic [BIN_W-1:0]     last_bin;
    logic [SH_W-1:0]      shift;
    logic                 out_valid;
    logic                 hs;
    logic                 at_bin0;
    logic                 at_end;
    logic                 in_band;
    logic                 early_last;
    logic                 missing_last;
    logic                 close;

    band_edge_table #(
        .FFT_LEN  (FFT_LEN),
        .BANDS    (BANDS),
        .EDGE_LOG (EDGE_LOG),
        .SKIP_DC  (SKIP_DC),
        .BIN_W    (BIN_W),
        .BAND_W   (BAND_W),
        .SH_W     (SH_W)
    ) u_edges (
        .band     (band),
        .last_bin (last_bin),
        .shift    (shift)
    );

    // held low in reset so nothing upstream sees a handshake that is then dropped
    assign s_axis_tready = rst_n && (!out_valid || m_axis_tready);
    assign m_axis_tvalid = out_valid;

    assign hs           = s_axis_tvalid && s_axis_tready;
    assign at_bin0      = (bin == '0);
    assign at_end       = (bin == '1);
    // upper half of the frame is the mirror image and never binned
    assign in_band      = !bin[BIN_W-1] && !((SKIP_DC != 0) && at_bin0);
    assign early_last   = s_axis_tlast && !at_end;
    assign missing_last = at_end && !s_axis_tlast;
    // a beat carrying an early tlast is part of a broken frame: never emit on it
    assign close        = hs && in_band && !early_last && (bin == last_bin);
    // the mode for the whole frame is whatever arrives with bin 0
    assign mode_eff     = at_bin0 ? decode_mode(cfg_mode) : mode_q;
    assign din_ext      = ACC_W'(s_axis_tdata);

    always_comb begin
        new_val = din_ext;
        if (!acc_empty) begin
            if (mode_eff == MODE_PEAK)
                new_val = (din_ext > acc) ? din_ext : acc;
            else
                new_val = acc + din_ext;
        end
    end

    assign mean_full = new_val >> shift;

    // the power-of-two mean can exceed full scale by up to 2x on non-power-of-two
    // widths; clip instead of wrapping
    always_comb begin
        result = new_val[ACC_W-1 -: OUT_WIDTH];
        case (mode_eff)
            MODE_PEAK: result = new_val[IN_WIDTH-1 -: OUT_WIDTH];
            MODE_MEAN: result = (|mean_full[ACC_W-1:IN_WIDTH]) ? '1
                                                               : mean_full[IN_WIDTH-1 -: OUT_WIDTH];
            default:   ;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            bin          <= '0;
            band         <= '0;
            mode_q       <= MODE_SUM;
            acc          <= '0;
            acc_empty    <= 1'b1;
            out_valid    <= 1'b0;
            m_axis_tdata <= '0;
            m_axis_tuser <= '0;
            m_axis_tlast <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            frame_err <= hs && (early_last || missing_last);

            if (close) begin
                out_valid    <= 1'b1;
                m_axis_tdata <= result;
                m_axis_tuser <= band;
                m_axis_tlast <= (band == BAND_W'(BANDS - 1));
            end else if (m_axis_tready) begin
                out_valid <= 1'b0;
            end

            if (hs) begin
                if (at_bin0)
                    mode_q <= mode_eff;
                if (early_last || at_end) begin
                    bin       <= '0;
                    band      <= '0;
                    acc_empty <= 1'b1;
                end else begin
                    bin <= bin + 1'b1;
                    if (in_band) begin
                        acc       <= new_val;
                        acc_empty <= close;
                        if (close && band != BAND_W'(BANDS - 1))
                            band <= band + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_band_binner.sv
module tb_band_binner;

    localparam int FFT  = 1024;
    localparam int NB   = 32;
    // acc[28:13]: 24-bit input plus 5 bits for a 16-bin band
    localparam int A_SUM_SHIFT = 13;

    typedef struct {
        int user;
        int data;
        bit last;
    } beat_t;

    logic clk;
    logic rst_n;

    logic [1:0]  a_cfg_mode, b_cfg_mode;
    logic        a_s_valid, b_s_valid;
    logic        a_s_ready, b_s_ready;
    logic [23:0] a_s_data, b_s_data;
    logic        a_s_last, b_s_last;
    logic        a_m_valid, b_m_valid;
    logic        a_m_ready, b_m_ready;
    logic [15:0] a_m_data, b_m_data;
    logic [4:0]  a_m_user, b_m_user;
    logic        a_m_last, b_m_last;
    logic        a_ferr, b_ferr;

    int    errors = 0;
    int    checks = 0;
    int    frame_data [FFT];
    int    edges_a [NB+1];
    int    edges_b [NB+1];
    beat_t qa [$];
    beat_t qb [$];
    int    ferr_a = 0;
    int    ferr_b = 0;
    int    prev_b = 0;

    // A: linear edges, DC included
    band_binner #(
        .FFT_LEN(FFT), .BANDS(NB), .IN_WIDTH(24), .OUT_WIDTH(16), .EDGE_LOG(0), .SKIP_DC(0)
    ) dut_a (
        .clk_50m(clk), .rst_n(rst_n), .cfg_mode(a_cfg_mode),
        .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready), .s_axis_tdata(a_s_data),
        .s_axis_tlast(a_s_last), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
        .m_axis_tdata(a_m_data), .m_axis_tuser(a_m_user), .m_axis_tlast(a_m_last),
        .frame_err(a_ferr)
    );

    // B: log edges, DC skipped
    band_binner #(
        .FFT_LEN(FFT), .BANDS(NB), .IN_WIDTH(24), .OUT_WIDTH(16), .EDGE_LOG(1), .SKIP_DC(1)
    ) dut_b (
        .clk_50m(clk), .rst_n(rst_n), .cfg_mode(b_cfg_mode),
        .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready), .s_axis_tdata(b_s_data),
        .s_axis_tlast(b_s_last), .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
        .m_axis_tdata(b_m_data), .m_axis_tuser(b_m_user), .m_axis_tlast(b_m_last),
        .frame_err(b_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // expected bands of the frame in frame_data; only bands whose last bin lies
    // below emit_below are produced
    task automatic model_frame(input bit to_b, input int mode, input int emit_below);
        int     lo, hi, w, sh;
        longint sum, pk, v;
        beat_t  bt;
        for (int b = 0; b < NB; b++) begin
            lo = to_b ? edges_b[b] : edges_a[b];
            hi = to_b ? edges_b[b+1] : edges_a[b+1];
            if (hi - 1 >= emit_below)
                break;
            sum = 0;
            pk  = 0;
            for (int j = lo; j < hi; j++) begin
                sum += frame_data[j];
                if (frame_data[j] > pk)
                    pk = frame_data[j];
            end
            w  = hi - lo;
            sh = 0;
            while ((1 << (sh + 1)) <= w)
                sh++;
            case (mode)
                1: begin
                    v = sum >> sh;
                    if (v > 64'hFFFFFF)
                        v = 64'hFFFFFF;
                    v = v >> 8;
                end
                2:       v = pk >> 8;
                default: v = (sum >> A_SUM_SHIFT) & 64'hFFFF;
            endcase
            bt.user = b;
            bt.data = int'(v);
            bt.last = (b == NB - 1);
            if (to_b)
                qb.push_back(bt);
            else
                qa.push_back(bt);
        end
    endtask

    // drives beats 0..n-1 of frame_data; cfg_mode is scrambled after bin 0
    task automatic send(input bit to_b, input int mode, input int n,
                        input bit with_last, input bit throttle);
        int idx, cyc;
        bit hs, v, rdy;
        idx = 0;
        cyc = 0;
        hs  = 1'b0;
        @(posedge clk);
        while (idx < n) begin
            #1;
            v   = throttle ? ($urandom_range(0, 1) == 1) : 1'b1;
            rdy = throttle ? (cyc % 3 == 0) : 1'b1;
            if (to_b) begin
                b_s_valid  = v;
                b_s_data   = 24'(frame_data[idx]);
                b_s_last   = with_last && (idx == n - 1);
                b_cfg_mode = (idx == 0) ? 2'(mode) : 2'((mode + 1) % 3);
                b_m_ready  = rdy;
            end else begin
                a_s_valid  = v;
                a_s_data   = 24'(frame_data[idx]);
                a_s_last   = with_last && (idx == n - 1);
                a_cfg_mode = (idx == 0) ? 2'(mode) : 2'((mode + 1) % 3);
                a_m_ready  = rdy;
            end
            @(negedge clk);
            hs = to_b ? (b_s_valid && b_s_ready) : (a_s_valid && a_s_ready);
            @(posedge clk);
            if (hs)
                idx++;
            cyc++;
            if (cyc > n * 8 + 100) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got=%0d beats exp=%0d", idx, n);
                break;
            end
        end
        #1;
        a_s_valid = 1'b0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_m_ready = 1'b1;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((qa.size() + qb.size()) != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        repeat (3) @(posedge clk);
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && a_m_valid && a_m_ready) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_extra_beat got user=%0d data=%0d exp=none", a_m_user, a_m_data);
            end else begin
                e = qa.pop_front();
                if (a_m_user != 5'(e.user) || a_m_data != 16'(e.data) || a_m_last != e.last) begin
                    errors++;
                    $display("FAIL a_beat got user=%0d data=%0d last=%0d exp user=%0d data=%0d last=%0d",
                             a_m_user, a_m_data, a_m_last, e.user, e.data, e.last);
                end
            end
        end
        if (rst_n && a_ferr)
            ferr_a++;
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst_n && b_m_valid && b_m_ready) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_extra_beat got user=%0d data=%0d exp=none", b_m_user, b_m_data);
            end else begin
                e = qb.pop_front();
                if (b_m_user != 5'(e.user) || b_m_data != 16'(e.data) || b_m_last != e.last) begin
                    errors++;
                    $display("FAIL b_beat got user=%0d data=%0d last=%0d exp user=%0d data=%0d last=%0d",
                             b_m_user, b_m_data, b_m_last, e.user, e.data, e.last);
                end
            end
            // peak of a j<<8 ramp reveals each band's last bin: must rise every band
            if (b_m_user != 0) begin
                checks++;
                if (int'(b_m_data) <= prev_b) begin
                    errors++;
                    $display("FAIL b_edge_increase got=%0d exp_above=%0d", b_m_data, prev_b);
                end
            end
            if (b_m_user == 5'd31)
                chk("b_total_span", b_m_data, 511);
            prev_b = int'(b_m_data);
        end
        if (rst_n && b_ferr)
            ferr_b++;
    end

    initial begin
        rst_n = 1'b0;
        a_cfg_mode = 2'd0; a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0; a_m_ready = 1'b1;
        b_cfg_mode = 2'd0; b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
        for (int b = 0; b <= NB; b++) begin
            edges_a[b] = b * 16;
            edges_b[b] = band_pkg::band_edge(b, FFT, NB, 1, 1);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_s_ready", a_s_ready, 0);
        chk("rst_frame_err", a_ferr, 0);
        chk("rst_m_data", a_m_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all bins 1000, sum: every band 16000 -> acc[28:13] = 1
        for (int j = 0; j < FFT; j++) frame_data[j] = 1000;
        model_frame(0, 0, FFT);
        send(0, 0, FFT, 1, 0);
        wait_drain();
        chk("t1_frame_err", ferr_a, 0);

        // peak, single full-scale bin 37 -> band 2 = 0xFFFF
        for (int j = 0; j < FFT; j++) frame_data[j] = 0;
        frame_data[37] = 24'hFFFFFF;
        model_frame(0, 2, FFT);
        send(0, 2, FFT, 1, 0);
        wait_drain();
        chk("t2_frame_err", ferr_a, 0);

        // early tlast at bin 300 -> bands 0..17 only, one frame_err
        for (int j = 0; j < FFT; j++) frame_data[j] = j * 997;
        model_frame(0, 0, 300);
        send(0, 0, 301, 1, 0);
        wait_drain();
        chk("t3_frame_err_early", ferr_a, 1);

        // next frame in mean mode is complete
        for (int j = 0; j < FFT; j++) frame_data[j] = j * 1000;
        model_frame(0, 1, FFT);
        send(0, 1, FFT, 1, 0);
        wait_drain();
        chk("t3_frame_err_after", ferr_a, 1);

        // missing tlast at bin 1023: bands intact, frame_err, wrap anyway
        for (int j = 0; j < FFT; j++) frame_data[j] = 24'hFFFFFF - j * 5000;
        model_frame(0, 0, FFT);
        send(0, 0, FFT, 0, 0);
        wait_drain();
        chk("missing_last_err", ferr_a, 2);

        // throttled output and gappy input, random magnitudes
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < FFT; j++) frame_data[j] = int'($urandom_range(0, 24'hFFFFFF));
            model_frame(0, 0, FFT);
            send(0, 0, FFT, 1, 1);
        end
        wait_drain();
        chk("t4_frame_err", ferr_a, 2);

        // log edges with DC skipped: bin 0 and upper half loud, ramp j<<8 inside
        for (int j = 0; j < FFT; j++) frame_data[j] = (j < FFT / 2) ? (j << 8) : 24'hFFFFFF;
        frame_data[0] = 24'hFFFFFF;
        model_frame(1, 2, FFT);
        send(1, 2, FFT, 1, 0);
        wait_drain();
        chk("t5_frame_err", ferr_b, 0);

        // reset at bin 200, then a clean frame
        for (int j = 0; j < FFT; j++) frame_data[j] = j * 3001;
        model_frame(0, 0, 200);
        send(0, 0, 200, 0, 0);
        wait_drain();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_m_valid", a_m_valid, 0);
        chk("t6_rst_m_data", a_m_data, 0);
        chk("t6_rst_m_user", a_m_user, 0);
        chk("t6_rst_m_last", a_m_last, 0);
        chk("t6_rst_frame_err", a_ferr, 0);
        chk("t6_rst_s_ready", a_s_ready, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < FFT; j++) frame_data[j] = j * 4099;
        model_frame(0, 2, FFT);
        send(0, 2, FFT, 1, 0);
        wait_drain();
        chk("t6_frame_err", ferr_a, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
